// File: rtl/hex_scroll_ctrl.sv
// Scrolling marquee controller for the eight DE2 seven-segment displays.
// An 8-entry buffer of 3-bit character codes is loaded from switches and
// rotated across HEX7..HEX0 at a programmable rate, with pause/resume.
// Ports:
//   CLOCK_50     system clock
//   KEY[0]       synchronous active-low reset (sampled directly)
//   KEY[1]       commit character (active-low pushbutton)
//   KEY[2]       pause/resume toggle (active-low pushbutton)
//   SW[17:15]    character code, SW[0] mode (0 load, 1 scroll)
//   HEX0..HEX7   segments a..g, active-low, HEX7 leftmost
//   LEDR[2:0]    write pointer, LEDR[3] high while paused
module hex_scroll_ctrl #(
  parameter int unsigned TICK_DIV   = 25000000,
  parameter int unsigned NUM_DIGITS = 8
) (
  input  logic        CLOCK_50,
  input  logic [3:0]  KEY,
  input  logic [17:0] SW,
  output logic [0:6]  HEX0,
  output logic [0:6]  HEX1,
  output logic [0:6]  HEX2,
  output logic [0:6]  HEX3,
  output logic [0:6]  HEX4,
  output logic [0:6]  HEX5,
  output logic [0:6]  HEX6,
  output logic [0:6]  HEX7,
  output logic [3:0]  LEDR
);

  localparam int unsigned CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned PW = $clog2(NUM_DIGITS);

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    SCROLL = 2'd1,
    PAUSE  = 2'd2
  } state_t;

  state_t          state;
  logic [2:0]      char_buf [NUM_DIGITS];
  logic [PW-1:0]   offset;
  logic [PW-1:0]   wptr;
  logic [CW-1:0]   tick_cnt;

  logic            mode_s1, mode_s2;
  logic            commit_s1, commit_s2, commit_prev;
  logic            pause_s1, pause_s2, pause_prev;

  logic            commit;
  logic            pause_press;
  logic            tick;
  logic            unused_inputs;

  // One-cycle press pulses on the synchronised falling edge.
  assign commit      = commit_prev & ~commit_s2;
  assign pause_press = pause_prev & ~pause_s2;
  assign tick        = (state == SCROLL) && (tick_cnt == CW'(TICK_DIV - 1));

  assign unused_inputs = ^{KEY[3], SW[14:1]};

  // Sequencing, synchronisers and buffer update.
  always_ff @(posedge CLOCK_50) begin
    if (!KEY[0]) begin
      state       <= LOAD;
      char_buf[0] <= 3'd0;
      char_buf[1] <= 3'd1;
      char_buf[2] <= 3'd2;
      char_buf[3] <= 3'd2;
      char_buf[4] <= 3'd3;
      char_buf[5] <= 3'd4;
      char_buf[6] <= 3'd4;
      char_buf[7] <= 3'd4;
      offset      <= '0;
      wptr        <= '0;
      tick_cnt    <= '0;
      // Mode clears to load so a released reset never starts scrolling early.
      mode_s1     <= 1'b0;
      mode_s2     <= 1'b0;
      commit_s1   <= 1'b1;
      commit_s2   <= 1'b1;
      commit_prev <= 1'b1;
      pause_s1    <= 1'b1;
      pause_s2    <= 1'b1;
      pause_prev  <= 1'b1;
    end else begin
      mode_s1     <= SW[0];
      mode_s2     <= mode_s1;
      commit_s1   <= KEY[1];
      commit_s2   <= commit_s1;
      commit_prev <= commit_s2;
      pause_s1    <= KEY[2];
      pause_s2    <= pause_s1;
      pause_prev  <= pause_s2;

      case (state)
        LOAD: begin
          offset   <= '0;
          tick_cnt <= '0;
          if (commit) begin
            char_buf[wptr] <= SW[17:15];
            wptr           <= wptr + PW'(1);
          end
          if (mode_s2) state <= SCROLL;
        end
        SCROLL: begin
          if (!mode_s2) begin
            state    <= LOAD;
            offset   <= '0;
            tick_cnt <= '0;
          end else begin
            if (tick) begin
              tick_cnt <= '0;
              offset   <= offset + PW'(1);
            end else begin
              tick_cnt <= tick_cnt + CW'(1);
            end
            if (pause_press) state <= PAUSE;
          end
        end
        PAUSE: begin
          if (!mode_s2) begin
            state    <= LOAD;
            offset   <= '0;
            tick_cnt <= '0;
          end else if (pause_press) begin
            state <= SCROLL;
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

  // Character code to active-low a..g pattern.
  function automatic logic [0:6] seg7(input logic [2:0] code);
    case (code)
      3'd0:    seg7 = 7'b1001000;
      3'd1:    seg7 = 7'b0110000;
      3'd2:    seg7 = 7'b1110001;
      3'd3:    seg7 = 7'b0000001;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  // HEXk shows buf[(offset + 7 - k) mod 8]; PW-bit addition gives the wrap.
  logic [0:6] seg [NUM_DIGITS];
  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_disp
    assign seg[k] = seg7(char_buf[offset + PW'(NUM_DIGITS - 1 - k)]);
  end

  assign HEX0 = seg[0];
  assign HEX1 = seg[1];
  assign HEX2 = seg[2];
  assign HEX3 = seg[3];
  assign HEX4 = seg[4];
  assign HEX5 = seg[5];
  assign HEX6 = seg[6];
  assign HEX7 = seg[7];

  assign LEDR = {(state == PAUSE), wptr};

endmodule

// File: tb/tb_hex_scroll_ctrl.sv
// Self-checking bench for hex_scroll_ctrl with TICK_DIV=4.
module tb_hex_scroll_ctrl;

  logic        clk = 1'b0;
  logic [3:0]  KEY;
  logic [17:0] SW;
  logic [0:6]  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5, HEX6, HEX7;
  logic [3:0]  LEDR;

  int n_tests = 0;
  int n_fail  = 0;

  hex_scroll_ctrl #(.TICK_DIV(4), .NUM_DIGITS(8)) dut (
    .CLOCK_50 (clk),
    .KEY      (KEY),
    .SW       (SW),
    .HEX0     (HEX0),
    .HEX1     (HEX1),
    .HEX2     (HEX2),
    .HEX3     (HEX3),
    .HEX4     (HEX4),
    .HEX5     (HEX5),
    .HEX6     (HEX6),
    .HEX7     (HEX7),
    .LEDR     (LEDR)
  );

  always #10 clk = ~clk;

  // Reference model state
  logic [2:0] mbuf [8];
  int         moff;
  int         mwptr;
  logic       mpause;

  typedef struct {
    string       name;
    logic [55:0] disp;
    logic [3:0]  ledr;
  } exp_t;
  exp_t sbq [$];

  typedef struct {
    logic [2:0] code;
    logic [6:0] seg;
  } vec_t;
  vec_t vecs [8];

  function automatic logic [6:0] seg_of(input logic [2:0] code);
    case (code)
      3'd0:    return 7'b1001000;
      3'd1:    return 7'b0110000;
      3'd2:    return 7'b1110001;
      3'd3:    return 7'b0000001;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [55:0] model_disp();
    logic [55:0] d;
    for (int k = 0; k < 8; k++) d[k*7 +: 7] = seg_of(mbuf[(moff + 7 - k) % 8]);
    return d;
  endfunction

  function automatic logic [6:0] get_hex(input int k);
    case (k)
      0: return HEX0;
      1: return HEX1;
      2: return HEX2;
      3: return HEX3;
      4: return HEX4;
      5: return HEX5;
      6: return HEX6;
      default: return HEX7;
    endcase
  endfunction

  task automatic model_reset();
    mbuf[0] = 3'd0; mbuf[1] = 3'd1; mbuf[2] = 3'd2; mbuf[3] = 3'd2;
    mbuf[4] = 3'd3; mbuf[5] = 3'd4; mbuf[6] = 3'd4; mbuf[7] = 3'd4;
    moff = 0; mwptr = 0; mpause = 1'b0;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Push the model's view of the display for the stimulus just applied.
  task automatic push_exp(input string name);
    exp_t e;
    e.name = name;
    e.disp = model_disp();
    e.ledr = {mpause, 3'(mwptr)};
    sbq.push_back(e);
  endtask

  // Pop every pending expectation and compare against the DUT now.
  task automatic check_out();
    exp_t e;
    logic [55:0] act;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      act = {HEX7, HEX6, HEX5, HEX4, HEX3, HEX2, HEX1, HEX0};
      n_tests++;
      if (act !== e.disp || LEDR !== e.ledr) begin
        n_fail++;
        $display("FAIL %s: hex=%h ledr=%b, required hex=%h ledr=%b",
                 e.name, act, LEDR, e.disp, e.ledr);
      end
    end
  endtask

  task automatic expect_now(input string name);
    push_exp(name);
    check_out();
  endtask

  task automatic do_reset();
    KEY[0] = 1'b0;
    cyc(2);
    KEY[0] = 1'b1;
    model_reset();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{3'd4, 7'b1111111};
    vecs[1] = '{3'd1, 7'b0110000};
    vecs[2] = '{3'd2, 7'b1110001};
    vecs[3] = '{3'd3, 7'b0000001};
    vecs[4] = '{3'd0, 7'b1001000};
    vecs[5] = '{3'd7, 7'b1111111};
    vecs[6] = '{3'd6, 7'b1111111};
    vecs[7] = '{3'd5, 7'b1111111};

    KEY = 4'hF;
    SW  = '0;
    model_reset();
    cyc(1);

    // Reset state
    do_reset();
    push_exp("reset");
    cyc(1);
    check_out();

    // Single commit while held for 10 cycles
    SW[17:15] = 3'd3;
    KEY[1] = 1'b0;
    cyc(2);
    expect_now("commit_before_3rd_edge");
    cyc(1);
    mbuf[0] = 3'd3; mwptr = 1;
    expect_now("commit_3rd_edge");
    cyc(7);
    KEY[1] = 1'b1;
    cyc(3);
    expect_now("commit_held_once");

    // Table-driven loads across every character code, wrapping wptr
    for (int i = 0; i < 8; i++) begin
      int w;
      w = mwptr;
      SW[17:15] = vecs[i].code;
      KEY[1] = 1'b0;
      cyc(3);
      KEY[1] = 1'b1;
      mbuf[w] = vecs[i].code;
      mwptr = (mwptr + 1) % 8;
      push_exp($sformatf("load_vec%0d", i));
      cyc(3);
      check_out();
      n_tests++;
      if (get_hex(7 - w) !== vecs[i].seg) begin
        n_fail++;
        $display("FAIL load_seg%0d: HEX%0d=%b, required %b", i, 7 - w,
                 get_hex(7 - w), vecs[i].seg);
      end
    end

    // Scrolling from reset
    do_reset();
    SW[0] = 1'b1;
    cyc(6);
    expect_now("scroll_before_step");
    cyc(1);
    moff = 1;
    expect_now("scroll_step1");
    cyc(8);
    moff = 3;
    expect_now("scroll_off3");
    cyc(20);
    moff = 0;
    expect_now("scroll_wrap");

    // Pause and resume
    KEY[2] = 1'b0;
    cyc(3);
    mpause = 1'b1;
    expect_now("pause_on");
    KEY[2] = 1'b1;
    cyc(40);
    expect_now("pause_hold40");
    KEY[2] = 1'b0;
    cyc(3);
    mpause = 1'b0;
    expect_now("resume");
    KEY[2] = 1'b1;
    cyc(1);
    moff = 1;
    expect_now("resume_step");

    // Mode drop wins over a same-cycle pause press
    cyc(8);
    moff = 3;
    expect_now("prio_off3");
    KEY[2] = 1'b0;
    cyc(3);
    mpause = 1'b1;
    expect_now("prio_paused");
    KEY[2] = 1'b1;
    cyc(4);
    SW[0] = 1'b0;
    KEY[2] = 1'b0;
    cyc(2);
    expect_now("prio_before");
    cyc(1);
    mpause = 1'b0; moff = 0;
    expect_now("prio_load");
    KEY[2] = 1'b1;

    // A commit in load after scrolling keeps buffer and wptr semantics
    SW[17:15] = 3'd1;
    KEY[1] = 1'b0;
    cyc(3);
    KEY[1] = 1'b1;
    mbuf[0] = 3'd1; mwptr = 1;
    expect_now("load_after_prio");
    cyc(3);

    // Reset mid-scroll with a commit in the synchroniser
    SW[0] = 1'b1;
    cyc(23);
    moff = 5;
    expect_now("mid_off5");
    KEY[1] = 1'b0;
    SW[0] = 1'b0;
    cyc(1);
    KEY[0] = 1'b0;
    cyc(2);
    KEY[0] = 1'b1;
    KEY[1] = 1'b1;
    model_reset();
    cyc(4);
    expect_now("reset_mid");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
